// File: rtl/ring_pkg.sv
// ============================================================================
//  Module      : ring_pkg
//  Description : Shared types and helpers for the ring counter receive decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_pkg;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_IDX_W = 2;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // The hot bit walks downward; position 0 wraps to N-1. Compare instead of
    // relying on overflow so that non-power-of-two rings work.
    function automatic int unsigned next_idx(input int unsigned prev, input int unsigned n);
        return (prev == 0) ? (n - 1) : (prev - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_to_idx.sv
// ============================================================================
//  Module      : onehot_to_idx
//  Description : Combinational one-hot to binary encoder with legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_to_idx
    import ring_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     ring,
    output logic [IDX_W-1:0] idx,
    output logic             legal
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] pop_cnt;

    // OR-encoder: only meaningful when exactly one bit is set, which legal reports.
    always_comb begin
        pop_cnt = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            pop_cnt = pop_cnt + CNT_W'(ring[i]);
            if (ring[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        legal = (pop_cnt == CNT_W'(1));
    end

endmodule

`default_nettype wire

// File: rtl/ring_seq_decoder.sv
// ============================================================================
//  Module      : ring_seq_decoder
//  Description : Ring counter receiver: decode, order check, lock, rotation/error counts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_seq_decoder
    import ring_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned IDX_W    = $clog2(N),
    parameter int unsigned LOCK_RUN = 3,
    parameter int unsigned ROT_W    = 8
) (
    input  logic             clock,
    input  logic             Resetn,
    input  logic [N-1:0]     ring,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic             idx_vld,
    output logic             locked,
    output logic             code_err,
    output logic             seq_err,
    output logic [ROT_W-1:0] rot_cnt,
    output logic [7:0]       err_cnt
);

    localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, run_inc;
    logic [IDX_W-1:0]  prev_idx_q, prev_idx_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              idx_vld_q, idx_vld_d;
    logic              code_err_q, code_err_d;
    logic              seq_err_q, seq_err_d;
    logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0]  dec_idx;
    logic              dec_legal;
    logic [IDX_W-1:0]  exp_idx;
    logic              in_order;
    logic              rot_inc;
    logic              err_inc;

    onehot_to_idx #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_dec (
        .ring  (ring),
        .idx   (dec_idx),
        .legal (dec_legal)
    );

    assign exp_idx  = IDX_W'(next_idx(32'(prev_idx_q), N));
    assign in_order = (dec_idx == exp_idx);
    assign run_inc  = run_q + RUN_W'(1);

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        prev_idx_d = prev_idx_q;
        idx_d      = idx_q;
        idx_vld_d  = idx_vld_q;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        rot_inc    = 1'b0;
        err_inc    = 1'b0;

        if (en) begin
            if (!dec_legal) begin
                idx_vld_d  = 1'b0;
                code_err_d = 1'b1;
                err_inc    = 1'b1;
                state_d    = HUNT;
                run_d      = '0;
            end else begin
                idx_d      = dec_idx;
                idx_vld_d  = 1'b1;
                prev_idx_d = dec_idx;
                case (state_q)
                    HUNT: begin
                        run_d   = RUN_W'(1);
                        state_d = (LOCK_RUN == 1) ? LOCKED : VERIFY;
                    end
                    VERIFY: begin
                        if (in_order) begin
                            run_d = run_inc;
                            if (run_inc == RUN_W'(LOCK_RUN)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            run_d = RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (in_order) begin
                            // A step from 1 into home position 0 completes a rotation.
                            rot_inc = (prev_idx_q == IDX_W'(1));
                        end else begin
                            seq_err_d = 1'b1;
                            err_inc   = 1'b1;
                            state_d   = HUNT;
                            run_d     = '0;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                        run_d   = '0;
                    end
                endcase
            end
        end

        rot_cnt_d = rot_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            rot_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            if (rot_inc && (rot_cnt_q != '1)) begin
                rot_cnt_d = rot_cnt_q + ROT_W'(1);
            end
            if (err_inc && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= HUNT;
            run_q      <= '0;
            prev_idx_q <= '0;
            idx_q      <= '0;
            idx_vld_q  <= 1'b0;
            code_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
            rot_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            prev_idx_q <= prev_idx_d;
            idx_q      <= idx_d;
            idx_vld_q  <= idx_vld_d;
            code_err_q <= code_err_d;
            seq_err_q  <= seq_err_d;
            rot_cnt_q  <= rot_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign idx      = idx_q;
    assign idx_vld  = idx_vld_q;
    assign locked   = (state_q == LOCKED);
    assign code_err = code_err_q;
    assign seq_err  = seq_err_q;
    assign rot_cnt  = rot_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_seq_decoder.sv
// ============================================================================
//  Module      : tb_ring_seq_decoder
//  Description : Directed self-checking bench for ring_seq_decoder (N=4, LOCK_RUN=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_seq_decoder;

    logic       clock;
    logic       Resetn;
    logic [3:0] ring;
    logic       en;
    logic       clr;
    logic [1:0] idx;
    logic       idx_vld;
    logic       locked;
    logic       code_err;
    logic       seq_err;
    logic [7:0] rot_cnt;
    logic [7:0] err_cnt;

    int vectors;
    int miscompares;

    ring_seq_decoder #(
        .N        (4),
        .IDX_W    (2),
        .LOCK_RUN (3),
        .ROT_W    (8)
    ) dut (
        .clock    (clock),
        .Resetn   (Resetn),
        .ring     (ring),
        .en       (en),
        .clr      (clr),
        .idx      (idx),
        .idx_vld  (idx_vld),
        .locked   (locked),
        .code_err (code_err),
        .seq_err  (seq_err),
        .rot_cnt  (rot_cnt),
        .err_cnt  (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_idx, input logic e_vld,
                           input logic e_lk, input logic e_ce, input logic e_se,
                           input logic [7:0] e_rot, input logic [7:0] e_err);
        chk({tag, ".idx"},      32'(idx),      32'(e_idx));
        chk({tag, ".idx_vld"},  32'(idx_vld),  32'(e_vld));
        chk({tag, ".locked"},   32'(locked),   32'(e_lk));
        chk({tag, ".code_err"}, 32'(code_err), 32'(e_ce));
        chk({tag, ".seq_err"},  32'(seq_err),  32'(e_se));
        chk({tag, ".rot_cnt"},  32'(rot_cnt),  32'(e_rot));
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(e_err));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step(input logic [3:0] r, input logic e, input logic c);
        ring = r;
        en   = e;
        clr  = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ring   = 4'b0000;
        en     = 1'b0;
        clr    = 1'b0;
        Resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        Resetn = 1'b1;

        // 1: basic decode, lock after third sample, first rotation
        step(4'b0001, 1, 0); chk_all("t1_s1", 2'd0, 1, 0, 0, 0, 8'd0, 8'd0);
        step(4'b1000, 1, 0); chk_all("t1_s2", 2'd3, 1, 0, 0, 0, 8'd0, 8'd0);
        step(4'b0100, 1, 0); chk_all("t1_s3", 2'd2, 1, 1, 0, 0, 8'd0, 8'd0);
        step(4'b0010, 1, 0); chk_all("t1_s4", 2'd1, 1, 1, 0, 0, 8'd0, 8'd0);
        step(4'b0001, 1, 0); chk_all("t1_s5", 2'd0, 1, 1, 0, 0, 8'd1, 8'd0);

        // 2: multi-hot code error, then relock
        step(4'b0110, 1, 0); chk_all("t2_err", 2'd0, 0, 0, 1, 0, 8'd1, 8'd1);
        step(4'b1000, 1, 0); chk_all("t2_r1",  2'd3, 1, 0, 0, 0, 8'd1, 8'd1);
        step(4'b0100, 1, 0); chk_all("t2_r2",  2'd2, 1, 0, 0, 0, 8'd1, 8'd1);
        step(4'b0010, 1, 0); chk_all("t2_r3",  2'd1, 1, 1, 0, 0, 8'd1, 8'd1);

        // 3: backward skip while locked, then all-zero sample
        step(4'b0001, 1, 0); chk_all("t3_a",   2'd0, 1, 1, 0, 0, 8'd2, 8'd1);
        step(4'b1000, 1, 0); chk_all("t3_b",   2'd3, 1, 1, 0, 0, 8'd2, 8'd1);
        step(4'b0100, 1, 0); chk_all("t3_c",   2'd2, 1, 1, 0, 0, 8'd2, 8'd1);
        step(4'b1000, 1, 0); chk_all("t3_seq", 2'd3, 1, 0, 0, 1, 8'd2, 8'd2);
        step(4'b0000, 1, 0); chk_all("t3_zero", 2'd3, 0, 0, 1, 0, 8'd2, 8'd3);

        // relock; prev 1->0 in VERIFY must not count a rotation
        step(4'b0100, 1, 0); chk_all("rl_1", 2'd2, 1, 0, 0, 0, 8'd2, 8'd3);
        step(4'b0010, 1, 0); chk_all("rl_2", 2'd1, 1, 0, 0, 0, 8'd2, 8'd3);
        step(4'b0001, 1, 0); chk_all("rl_3", 2'd0, 1, 1, 0, 0, 8'd2, 8'd3);

        // 4: enable low with a changing ring
        step(4'b1000, 0, 0); chk_all("t4_1", 2'd0, 1, 1, 0, 0, 8'd2, 8'd3);
        step(4'b0110, 0, 0); chk_all("t4_2", 2'd0, 1, 1, 0, 0, 8'd2, 8'd3);
        step(4'b0000, 0, 0); chk_all("t4_3", 2'd0, 1, 1, 0, 0, 8'd2, 8'd3);
        step(4'b0100, 0, 0); chk_all("t4_4", 2'd0, 1, 1, 0, 0, 8'd2, 8'd3);
        step(4'b1111, 0, 0); chk_all("t4_5", 2'd0, 1, 1, 0, 0, 8'd2, 8'd3);

        // 5: rotation saturation, clr on a wrap, stalled ring, err saturation
        for (int k = 0; k < 260; k++) begin
            step(4'b1000, 1, 0);
            step(4'b0100, 1, 0);
            step(4'b0010, 1, 0);
            step(4'b0001, 1, 0);
        end
        chk_all("t5_sat", 2'd0, 1, 1, 0, 0, 8'd255, 8'd3);
        step(4'b1000, 1, 0);
        step(4'b0100, 1, 0);
        step(4'b0010, 1, 0);
        step(4'b0001, 1, 1); chk_all("t5_clr",   2'd0, 1, 1, 0, 0, 8'd0, 8'd0);
        step(4'b0001, 1, 0); chk_all("t5_stall", 2'd0, 1, 0, 0, 1, 8'd0, 8'd1);
        for (int k = 0; k < 300; k++) begin
            step(4'b0000, 1, 0);
        end
        chk_all("t5_esat", 2'd0, 0, 0, 1, 0, 8'd0, 8'd255);
        step(4'b0000, 1, 1); chk_all("t5_eclr", 2'd0, 0, 0, 1, 0, 8'd0, 8'd0);

        // 6: asynchronous reset mid-VERIFY
        step(4'b1000, 1, 0); chk_all("t6_v1", 2'd3, 1, 0, 0, 0, 8'd0, 8'd0);
        step(4'b0100, 1, 0); chk_all("t6_v2", 2'd2, 1, 0, 0, 0, 8'd0, 8'd0);
        #2;
        Resetn = 1'b0;
        #1;
        chk_all("t6_arst", 2'd0, 0, 0, 0, 0, 8'd0, 8'd0);
        #2;
        Resetn = 1'b1;
        step(4'b0010, 1, 0); chk_all("t6_h1", 2'd1, 1, 0, 0, 0, 8'd0, 8'd0);
        step(4'b0001, 1, 0); chk_all("t6_h2", 2'd0, 1, 0, 0, 0, 8'd0, 8'd0);
        step(4'b1000, 1, 0); chk_all("t6_h3", 2'd3, 1, 1, 0, 0, 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
